// File: rtl/decryption_regfile_master.sv
// decryption_regfile_master
// Register-bus initiator for the decryption register file. Takes one access
// command at a time, issues a single-cycle read or write strobe, waits for
// the responder's done (bounded by TIMEOUT cycles) and hands back data and
// status on a valid/ready response port.
module decryption_regfile_master #(
  parameter int addr_witdth = 8,
  parameter int reg_width   = 16,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [addr_witdth-1:0] cmd_addr,
  input  logic [reg_width-1:0]   cmd_wdata,
  // response port
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [reg_width-1:0]   rsp_rdata,
  output logic                   rsp_error,
  output logic                   rsp_timeout,
  // register-file access bus
  output logic [addr_witdth-1:0] addr,
  output logic                   read,
  output logic                   write,
  output logic [reg_width-1:0]   wdata,
  input  logic [reg_width-1:0]   rdata,
  input  logic                   done,
  input  logic                   error
);

  // Counter holds 0..TIMEOUT-1 and stops there, so one spare bit is plenty.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [reg_width-1:0]   DATA_ZERO = {reg_width{1'b0}};
  localparam logic [addr_witdth-1:0] ADDR_ZERO = {addr_witdth{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state_q,       state_d;
  logic                   wr_q,          wr_d;
  logic [addr_witdth-1:0] addr_q,        addr_d;
  logic [reg_width-1:0]   wdata_q,       wdata_d;
  logic [CNT_W-1:0]       cnt_q,         cnt_d;
  logic [reg_width-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                   rsp_error_q,   rsp_error_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  // Next-state and capture logic for the access sequencer.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready is 1 in IDLE, so cmd_valid alone is the handshake.
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Strobe cycle; done seen here is deliberately not looked at.
        cnt_d   = CNT_ZERO;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over the timeout on the same edge.
        if (done) begin
          rsp_error_d   = error;
          rsp_timeout_d = 1'b0;
          if (!wr_q && !error) begin
            rsp_rdata_d = rdata;
          end else begin
            rsp_rdata_d = DATA_ZERO;
          end
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = DATA_ZERO;
          state_d       = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and holding registers; async reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= ADDR_ZERO;
      wdata_q       <= DATA_ZERO;
      cnt_q         <= CNT_ZERO;
      rsp_rdata_q   <= DATA_ZERO;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Handshakes and strobes decode from state only, so nothing on cmd_*
  // reaches the bus combinationally.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign read        = (state_q == ST_ISSUE) && !wr_q;
  assign write       = (state_q == ST_ISSUE) && wr_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_decryption_regfile_master.sv
// Directed self-checking bench for decryption_regfile_master. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_decryption_regfile_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic [7:0]  addr;
  logic        read, write;
  logic [15:0] wdata, rdata;
  logic        done, error;

  logic [15:0] mem [0:255];
  int          pass_cnt  = 0;
  int          check_cnt = 0;

  decryption_regfile_master #(
    .addr_witdth(8), .reg_width(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .addr(addr), .read(read), .write(write), .wdata(wdata),
    .rdata(rdata), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Present a command for one edge, then scramble cmd_* so late changes
  // would show up. Returns at the falling edge of the strobe cycle.
  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 8'hFF; cmd_wdata = 16'hFFFF;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({cmd_ready, rsp_valid, read, write, addr, wdata, rsp_error, rsp_timeout, rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_state: got %h expected %h",
               {cmd_ready, rsp_valid, read, write, addr, wdata, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    send_cmd(1'b1, 8'h12, 16'h0005);
    check_cnt++;
    if ({read, write, addr, wdata, cmd_ready, rsp_valid} !== {1'b0, 1'b1, 8'h12, 16'h0005, 1'b0, 1'b0})
      $display("FAIL wr_issue: got %h expected %h", {read, write, addr, wdata, cmd_ready, rsp_valid},
               {1'b0, 1'b1, 8'h12, 16'h0005, 1'b0, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({read, write, addr, wdata, rsp_valid} !== {1'b0, 1'b0, 8'h12, 16'h0005, 1'b0})
      $display("FAIL wr_wait_hold: got %h expected %h", {read, write, addr, wdata, rsp_valid},
               {1'b0, 1'b0, 8'h12, 16'h0005, 1'b0});
    else pass_cnt++;
    mem[addr] = wdata;
    done = 1'b1; error = 1'b0; rdata = 16'hBEEF;
    @(negedge clk);
    done = 1'b0; rdata = 16'h0000;
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL wr_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 16'h0000});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL wr_back_idle: got %b expected %b", {rsp_valid, cmd_ready}, 2'b01);
    else pass_cnt++;
  endtask

  task automatic test_read_after_write();
    send_cmd(1'b1, 8'h10, 16'h0003);
    @(negedge clk);
    mem[addr] = wdata;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    send_cmd(1'b0, 8'h10, 16'h0000);
    check_cnt++;
    if ({read, write, addr} !== {1'b1, 1'b0, 8'h10})
      $display("FAIL rd_issue: got %h expected %h", {read, write, addr}, {1'b1, 1'b0, 8'h10});
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({read, write} !== 2'b00)
      $display("FAIL rd_strobe_len: got %b expected %b", {read, write}, 2'b00);
    else pass_cnt++;
    done = 1'b1; rdata = mem[addr];
    @(negedge clk);
    done = 1'b0; rdata = 16'h0000;
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0003})
      $display("FAIL rd_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 16'h0003});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_error();
    send_cmd(1'b0, 8'h33, 16'h0000);
    // done raised during the strobe cycle must not end the access early
    done = 1'b1; error = 1'b1; rdata = 16'h1234;
    @(negedge clk);
    check_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL err_issue_done_ignored: got %b expected %b", rsp_valid, 1'b0);
    else pass_cnt++;
    @(negedge clk);
    done = 1'b0; error = 1'b0; rdata = 16'h0000;
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 16'h0000})
      $display("FAIL err_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b1, 1'b0, 16'h0000});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send_cmd(1'b0, 8'h40, 16'h0000);
    rsp_ready = 1'b0; rdata = 16'h5555;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    check_cnt++;
    if (early !== 0)
      $display("FAIL to_early_valid: got %0d early cycles expected %0d", early, 0);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b1, 1'b1, 16'h0000})
      $display("FAIL to_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b1, 1'b1, 16'h0000});
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(negedge clk);
    done = 1'b1; error = 1'b1; rdata = 16'h7777;
    @(negedge clk);
    done = 1'b0; error = 1'b0; rdata = 16'h0000;
    check_cnt++;
    if ({cmd_ready, rsp_valid, read, write, rsp_error, rsp_timeout, rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000})
      $display("FAIL to_idle_done_ignored: got %h expected %h",
               {cmd_ready, rsp_valid, read, write, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b0, 8'h20, 16'h0000);
    rsp_ready = 1'b0;
    @(negedge clk);
    done = 1'b1; rdata = 16'h00AA;
    @(negedge clk);
    done = 1'b0; rdata = 16'h0000;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      check_cnt++;
      if ({rsp_valid, cmd_ready, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA})
        $display("FAIL bp_hold_%0d: got %h expected %h", i,
                 {rsp_valid, cmd_ready, rsp_error, rsp_timeout, rsp_rdata},
                 {1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA});
      else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({rsp_valid, cmd_ready, rsp_rdata} !== {1'b0, 1'b1, 16'h00AA})
      $display("FAIL bp_release: got %h expected %h", {rsp_valid, cmd_ready, rsp_rdata},
               {1'b0, 1'b1, 16'h00AA});
    else pass_cnt++;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_cnt++;
    if ({read, write, addr, wdata} !== {1'b0, 1'b1, 8'h21, 16'h0055})
      $display("FAIL bp_next_issue: got %h expected %h", {read, write, addr, wdata},
               {1'b0, 1'b1, 8'h21, 16'h0055});
    else pass_cnt++;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL bp_next_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 16'h0000});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    // reset in the middle of WAIT, between clock edges
    send_cmd(1'b1, 8'h60, 16'h1111);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({read, write, rsp_valid, cmd_ready, addr, wdata} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000})
      $display("FAIL rst_mid_wait: got %h expected %h", {read, write, rsp_valid, cmd_ready, addr, wdata},
               {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    // reset during the strobe itself must drop read at once
    send_cmd(1'b0, 8'h50, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({read, write, cmd_ready} !== 3'b001)
      $display("FAIL rst_mid_issue: got %b expected %b", {read, write, cmd_ready}, 3'b001);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(1'b1, 8'h14, 16'h0004);
    check_cnt++;
    if ({read, write, addr, wdata} !== {1'b0, 1'b1, 8'h14, 16'h0004})
      $display("FAIL rst_after_issue: got %h expected %h", {read, write, addr, wdata},
               {1'b0, 1'b1, 8'h14, 16'h0004});
    else pass_cnt++;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_cnt++;
    if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL rst_after_resp: got %h expected %h", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
               {1'b1, 1'b0, 1'b0, 16'h0000});
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 16'h0000;
    rsp_ready = 1'b1; rdata = 16'h0000; done = 1'b0; error = 1'b0;
    test_reset();
    test_write();
    test_read_after_write();
    test_error();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
